// File: rtl/apb_master_arbiter_if.sv
// Bundle of request-side and APB-side signals for apb_master_arbiter.
//   req_*  : per-requester request inputs, one-hot req_ready back
//   rsp_*  : one-hot response pulse plus shared read data / status
//   p*     : APB4 master pins (paddr, psel, penable, pwrite, pwdata,
//            prdata, pready, pslverr)
// modport master : the arbiter's view
// modport slave  : the environment's view (requesters + APB slave)
interface apb_master_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic [31:0]           paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata,
        input  prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata,
        output prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter + APB4 transfer sequencer sharing one APB master
// bus among NUM_REQ single-beat requesters, with an ACCESS wait-state
// timeout (TIMEOUT_CYC, 0 disables it).
// Ports:
//   pclk     : APB clock, rising edge
//   preset_n : asynchronous active-low reset
//   bus      : apb_master_arbiter_if.master (request, response, APB pins)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate; req_ready to winner, latch its request
// SETUP   | psel=1, penable=0
// ACCESS  | psel=1, penable=1; wait for pready or timeout
module apb_master_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    apb_master_arbiter_if.master bus
);
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_gnt;
    logic [IDX_W-1:0]   w_gnt;
    logic [IDX_W-1:0]   w_cand;
    logic               w_gnt_vld;
    logic               w_grant;
    logic               w_done;
    logic               w_timeout;
    logic [NUM_REQ-1:0] w_req_ready;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_paddr;
    logic [31:0]        r_pwdata;
    logic               r_pwrite;
    logic               r_psel;
    logic               r_penable;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_rsp_timeout;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [31:0] v);
        return (v >= NUM_REQ) ? IDX_W'(v - NUM_REQ) : IDX_W'(v);
    endfunction

    // Scan from lowest to highest priority so the last hit wins; the
    // highest-priority slot is the one just after the previous winner.
    always_comb begin
        w_gnt     = r_last;
        w_gnt_vld = 1'b0;
        w_cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = wrap_idx(32'(r_last) + 32'(i));
            if (bus.req_valid[w_cand]) begin
                w_gnt     = w_cand;
                w_gnt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_gnt_vld) w_state_nxt = S_SETUP;
            S_SETUP:  w_state_nxt = S_ACCESS;
            S_ACCESS: if (bus.pready || w_timeout) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant     = (r_state == S_IDLE) && w_gnt_vld;
        w_done      = (r_state == S_ACCESS) && bus.pready;
        w_timeout   = (TIMEOUT_CYC != 0) && (r_state == S_ACCESS) && !bus.pready
                      && (r_cnt == CNT_W'(TO_LAST));
        w_req_ready = '0;
        if (w_grant) w_req_ready = ONE << w_gnt;
    end

    // Registered APB outputs follow the next state so psel/penable are
    // glitch-free and drop in the cycle after ACCESS ends.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_last        <= IDX_W'(NUM_REQ - 1);
            r_gnt         <= '0;
            r_cnt         <= '0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_psel    <= (w_state_nxt != S_IDLE);
            r_penable <= (w_state_nxt == S_ACCESS);

            if (w_grant) begin
                r_last   <= w_gnt;
                r_gnt    <= w_gnt;
                r_paddr  <= bus.req_addr[32*w_gnt +: 32];
                r_pwdata <= bus.req_wdata[32*w_gnt +: 32];
                r_pwrite <= bus.req_write[w_gnt];
                r_cnt    <= '0;
            end else if ((r_state == S_ACCESS) && !bus.pready) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            r_rsp_valid   <= '0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            if (w_done) begin
                r_rsp_valid <= ONE << r_gnt;
                r_rsp_err   <= bus.pslverr;
                r_rsp_rdata <= r_pwrite ? 32'h0 : bus.prdata;
            end else if (w_timeout) begin
                r_rsp_valid   <= ONE << r_gnt;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.pwrite      = r_pwrite;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Round-robin arbiter and transfer sequencer that shares one APB4 master bus among NUM_REQ requesters.
- Each requester presents a single-beat read or write request.
- The block grants one request, then drives the APB SETUP and ACCESS phases and waits on pready.
- It returns the read data and error status to the granted requester, and enforces a wait-state timeout.
- Sits between internal request sources and the APB master pins (paddr, psel, penable, pwrite, pwdata, prdata, pready, pslverr).

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYC, 255, max ACCESS cycles with pready=0 before abort; 0 disables the timeout

Ports:
pclk  input  1  APB clock; all logic on rising edge
preset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  request pending, per requester
req_ready  output  NUM_REQ  one-hot grant/accept, combinational
req_addr  input  NUM_REQ*32  per-requester address; requester i occupies bits [32i+31:32i]
req_write  input  NUM_REQ  1=write, 0=read
req_wdata  input  NUM_REQ*32  per-requester write data
rsp_valid  output  NUM_REQ  one-cycle one-hot response pulse
rsp_rdata  output  32  read data, shared by all requesters
rsp_err  output  1  pslverr or timeout, qualified by rsp_valid
rsp_timeout  output  1  timeout abort, qualified by rsp_valid
paddr  output  32  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  32  APB write data
prdata  input  32  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset state: FSM in IDLE. psel, penable, pwrite, paddr, pwdata, rsp_* all 0. RR pointer set so requester 0 has highest priority. Wait counter = 0.
- Reset mid-transfer: psel and penable drop asynchronously; the transfer is abandoned and no rsp_valid is issued.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered.
- IDLE:
  - If any req_valid is high, grant g = first requester with req_valid at or after (last_grant+1) mod NUM_REQ.
  - req_ready[g]=1 this cycle; req_ready is 0 outside IDLE.
  - Latch addr, write and wdata of g. Next state SETUP.
- SETUP: psel=1, penable=0, paddr/pwrite/pwdata stable. Next state ACCESS unconditionally.
- ACCESS: psel=1, penable=1.
  - pready=1: next state IDLE. Next cycle rsp_valid[g]=1 and rsp_err=pslverr. rsp_rdata=prdata for reads, 0 for writes. rsp_timeout=0.
  - pready=0: wait counter increments.
  - Counter reaches TIMEOUT_CYC (and TIMEOUT_CYC≠0): next state IDLE. Next cycle rsp_valid[g]=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The counter clears on entry to SETUP.
- Leaving ACCESS: psel and penable both drop to 0 on the next cycle. paddr, pwrite and pwdata hold their last values.
- rsp_valid lasts exactly one cycle. Requesters must always accept it; there is no backpressure.
- Throughput: the cycle carrying rsp_valid is IDLE, so a new grant may occur in that same cycle. A zero-wait transfer therefore takes 3 cycles (grant, SETUP, ACCESS) and back-to-back transfers issue every 3 cycles.
- Simultaneous requests: round-robin order; the pointer updates to g only on grant.
- Single requester asserting continuously: it is granted on every IDLE cycle.
- req_valid dropping before a grant is legal and nothing is issued. Request inputs are ignored after the grant.
- pslverr and prdata are sampled only in ACCESS when pready=1.

Test Plan:
- Single write: req0 write addr 0x1000, data 0xDEADBEEF, pready=1 immediately -> req_ready[0] at T0; psel=1/penable=0 at T1; penable=1 at T2; rsp_valid[0] at T3 with rsp_err=0, rsp_rdata=0.
- Read with wait states: req1 read 0x2004, pready low 3 ACCESS cycles, prdata=0x12345678 -> penable held 4 cycles; rsp_valid[1]=1, rsp_rdata=0x12345678.
- Arbitration: req0 and req1 both valid continuously, 4 transfers -> grant order 0,1,0,1; each grant issues 3 cycles after the previous one.
- Slave error: read with pready=1 and pslverr=1 -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYC=4, pready held 0 -> ACCESS lasts 4 cycles, psel drops; rsp_err=1, rsp_timeout=1, rsp_rdata=0; next request proceeds normally.
- Reset mid-ACCESS: assert preset_n=0 during penable=1 -> psel and penable go 0 immediately, no rsp_valid; after release, req0 has priority over req1 when both are valid.
